// File: rtl/game_tick_scheduler_pkg.sv
// Shared snake-game timing definitions: FSM state encodings and default timebase constants
// used by game_tick_scheduler and the other game timing blocks.
package game_tick_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_e;

  localparam int unsigned DEF_CNT_W       = 20;
  localparam logic [19:0] DEF_BASE_PERIOD = 20'd999_999;
  localparam logic [19:0] DEF_STEP        = 20'd100_000;
  localparam logic [19:0] DEF_MIN_PERIOD  = 20'd199_999;

endpackage

// File: rtl/game_tick_scheduler_tick_prescaler.sv
// Free-running prescaler: counts while enabled, wraps to zero on a >= terminal compare
// so a shrinking terminal value can never strand the counter above it.
module tick_prescaler #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             terminal_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign terminal_o = en_i && (count_q >= term_i);

  always_comb begin
    count_d = count_q;
    if (clr_i)           count_d = '0;
    else if (terminal_o) count_d = '0;
    else if (en_i)       count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Snake movement timebase: run/pause/stop FSM, speed level and period registers, and the
// tick/ack/overrun handshake. Optional `TICK_BOOST_EN adds boost_i (halves the terminal count).
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int unsigned      CNT_W       = DEF_CNT_W,
  parameter int unsigned      LEVELS      = 8,
  parameter logic [CNT_W-1:0] BASE_PERIOD = CNT_W'(DEF_BASE_PERIOD),
  parameter logic [CNT_W-1:0] STEP        = CNT_W'(DEF_STEP),
  parameter logic [CNT_W-1:0] MIN_PERIOD  = CNT_W'(DEF_MIN_PERIOD)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      pause_i,
  input  logic                      stop_i,
  input  logic                      level_up_i,
  input  logic                      tick_ack_i,
`ifdef TICK_BOOST_EN
  input  logic                      boost_i,
`endif
  output logic                      tick_o,
  output logic                      overrun_o,
  output logic [$clog2(LEVELS)-1:0] level_o,
  output logic [CNT_W-1:0]          period_o,
  output logic [1:0]                state_o
);

  localparam int unsigned   LW      = $clog2(LEVELS);
  localparam int unsigned   PW      = CNT_W + 3;
  localparam logic [LW-1:0] LVL_MAX = LW'(LEVELS - 1);

  state_e           state_q, state_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] period_q, period_d, term_val;
  logic             tick_q, tick_d, ovr_q, ovr_d;
  logic             cnt_en, cnt_clr, terminal;
  logic [PW-1:0]    red_w, diff_w;

`ifdef TICK_BOOST_EN
  assign term_val = boost_i ? (period_q >> 1) : period_q;
`else
  assign term_val = period_q;
`endif

  assign cnt_en = (state_q == ST_RUN);

  tick_prescaler #(.CNT_W(CNT_W)) u_presc (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .term_i     (term_val),
    .terminal_o (terminal)
  );

  // Strict priority stop > pause > start; a held pause also blocks start in any state.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    if (stop_i) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else if (pause_i) begin
      if (state_q == ST_RUN) state_d = ST_PAUSED;
    end else if (start_i) begin
      if (state_q == ST_IDLE) cnt_clr = 1'b1;
      state_d = ST_RUN;
    end
  end

  // A terminal always (re)asserts tick; it only counts as an overrun if the old tick went unacked.
  always_comb begin
    tick_d = tick_q;
    ovr_d  = ovr_q;
    if (stop_i) begin
      tick_d = 1'b0;
      ovr_d  = 1'b0;
    end else if (terminal) begin
      tick_d = 1'b1;
      if (tick_q && !tick_ack_i) ovr_d = 1'b1;
    end else if (tick_q && tick_ack_i) begin
      tick_d = 1'b0;
    end
  end

  always_comb begin
    level_d = level_q;
    if (stop_i)                                level_d = '0;
    else if (level_up_i && level_q != LVL_MAX) level_d = level_q + LW'(1);
  end

  // Wide arithmetic so a large level*STEP clamps to the floor instead of wrapping.
  always_comb begin
    red_w    = PW'(level_q) * PW'(STEP);
    diff_w   = PW'(BASE_PERIOD) - red_w;
    period_d = CNT_W'(diff_w);
    if (red_w >= PW'(BASE_PERIOD) || diff_w < PW'(MIN_PERIOD)) period_d = MIN_PERIOD;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      period_q <= BASE_PERIOD;
      tick_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      ovr_q    <= ovr_d;
    end
  end

  assign tick_o    = tick_q;
  assign overrun_o = ovr_q;
  assign level_o   = level_q;
  assign period_o  = period_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model built from the timing rules.
module tb_game_tick_scheduler;

  localparam int CNT_W = 20;
  localparam int LEVELS = 8;
  localparam int BASE = 9;
  localparam int STP = 2;
  localparam int MINP = 3;
`ifdef TICK_BOOST_EN
  localparam bit BOOST_ON = 1'b1;
`else
  localparam bit BOOST_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_r, start_r, pause_r, stop_r, lvl_r, ack_r, boost_r;
  logic tick_o, ovr_o;
  logic [2:0] level_o;
  logic [CNT_W-1:0] period_o;
  logic [1:0] state_o;

  game_tick_scheduler #(
    .CNT_W(CNT_W), .LEVELS(LEVELS),
    .BASE_PERIOD(20'd9), .STEP(20'd2), .MIN_PERIOD(20'd3)
  ) dut (
    .clock_i    (clk),
    .reset_i    (rst_r),
    .start_i    (start_r),
    .pause_i    (pause_r),
    .stop_i     (stop_r),
    .level_up_i (lvl_r),
    .tick_ack_i (ack_r),
`ifdef TICK_BOOST_EN
    .boost_i    (boost_r),
`endif
    .tick_o     (tick_o),
    .overrun_o  (ovr_o),
    .level_o    (level_o),
    .period_o   (period_o),
    .state_o    (state_o)
  );

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  bit rose, prev_tick, auto_ack;

  // Model state: 0 idle, 1 run, 2 paused
  int m_state, m_count, m_level, m_period;
  bit m_tick, m_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int calc_p(input int lvl);
    int p;
    p = BASE - lvl * STP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_step();
    int eff, nper;
    bit term;
    eff  = (BOOST_ON && boost_r) ? m_period / 2 : m_period;
    term = (m_state == 1) && (m_count >= eff);
    nper = calc_p(m_level);
    if (rst_r) begin
      m_state = 0; m_count = 0; m_level = 0; m_period = BASE; m_tick = 0; m_ovr = 0;
    end else if (stop_r) begin
      m_state = 0; m_count = 0; m_level = 0; m_period = nper; m_tick = 0; m_ovr = 0;
    end else begin
      if (m_state == 1) m_count = term ? 0 : m_count + 1;
      if (term) begin
        if (m_tick && !ack_r) m_ovr = 1;
        m_tick = 1;
      end else if (m_tick && ack_r) m_tick = 0;
      if (pause_r) begin
        if (m_state == 1) m_state = 2;
      end else if (start_r) begin
        if (m_state == 0) m_count = 0;
        m_state = 1;
      end
      if (lvl_r && m_level < LEVELS - 1) m_level++;
      m_period = nper;
    end
  endtask

  task automatic step();
    if (auto_ack) ack_r = m_tick;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    rose = tick_o && !prev_tick;
    prev_tick = tick_o;
    chk("tick", tick_o, m_tick);
    chk("overrun", ovr_o, m_ovr);
    chk("level", level_o, m_level);
    chk("period", period_o, m_period);
    chk("state", state_o, m_state);
  endtask

  task automatic wait_rise(input int bound, output bit found);
    found = 0;
    for (int k = 0; k < bound && !found; k++) begin
      step();
      found = rose;
    end
  endtask

  task automatic spacing(input string tag, input int exp);
    int c0;
    bit f;
    wait_rise(40, f);
    chk({tag, "_rise0"}, f, 1);
    c0 = cyc;
    wait_rise(40, f);
    chk({tag, "_rise1"}, f, 1);
    chk(tag, cyc - c0, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tick"}, tick_o, 0);
    chk({tag, "_ovr"}, ovr_o, 0);
    chk({tag, "_level"}, level_o, 0);
    chk({tag, "_period"}, period_o, 9);
    chk({tag, "_state"}, state_o, 0);
  endtask

  int t2_p[5] = '{7, 5, 3, 3, 3};
  int t2_g[5] = '{8, 6, 4, 4, 4};

  initial begin
    bit f;
    int n, gap;
    {start_r, pause_r, stop_r, lvl_r, ack_r, boost_r} = '0;
    auto_ack = 0; prev_tick = 0;
    rst_r = 1;
    step(); step();
    rst_r = 0;
    chk_reset_vals("rst");

    // 1: steady ticks with prompt ack
    auto_ack = 1;
    start_r = 1; step(); start_r = 0;
    spacing("t1_gap", 10);
    chk("t1_period", period_o, 9);
    chk("t1_ovr", ovr_o, 0);

    // 2: speed levels and saturation
    for (int i = 0; i < 5; i++) begin
      lvl_r = 1; step(); lvl_r = 0; step();
      chk("t2_level", level_o, i + 1);
      chk("t2_period", period_o, t2_p[i]);
      spacing("t2_gap", t2_g[i]);
    end
    repeat (4) begin lvl_r = 1; step(); lvl_r = 0; step(); end
    chk("t2_sat", level_o, 7);

    // 3: unacked tick -> overrun at second terminal, stop clears
    stop_r = 1; step(); stop_r = 0; step(); step();
    auto_ack = 0; ack_r = 0;
    start_r = 1; step(); start_r = 0;
    wait_rise(30, f);
    chk("t3_rise", f, 1);
    repeat (9) step();
    chk("t3_ovr0", ovr_o, 0);
    chk("t3_held", tick_o, 1);
    step();
    chk("t3_ovr1", ovr_o, 1);
    stop_r = 1; step(); stop_r = 0;
    chk("t3_stop_tick", tick_o, 0);
    chk("t3_stop_ovr", ovr_o, 0);
    chk("t3_stop_state", state_o, 0);

    // 4: pause freezes the count, resume continues from it
    step();
    auto_ack = 1;
    start_r = 1; step(); start_r = 0;
    n = 0;
    while (m_count != 4 && n < 50) begin step(); n++; end
    chk("t4_reach4", m_count, 4);
    pause_r = 1; n = 0;
    repeat (20) begin step(); n += int'(rose); end
    pause_r = 0;
    chk("t4_paused_ticks", n, 0);
    chk("t4_paused_state", state_o, 2);
    start_r = 1; step(); start_r = 0;
    gap = 1;
    while (!rose && gap < 30) begin step(); gap++; end
    chk("t4_resume_gap", gap, 6);

    // 5: priority and same-cycle corner cases
    stop_r = 1; pause_r = 1; start_r = 1; step();
    stop_r = 0; pause_r = 0; start_r = 0;
    chk("t5_idle", state_o, 0);
    lvl_r = 1; step();
    stop_r = 1; step(); stop_r = 0; lvl_r = 0;
    chk("t5_lvl_stop", level_o, 0);
    step(); step();
    auto_ack = 0; ack_r = 0;
    start_r = 1; step(); start_r = 0;
    wait_rise(30, f);
    chk("t5_rise", f, 1);
    n = 0;
    while (m_count != m_period && n < 30) begin step(); n++; end
    ack_r = 1; step(); ack_r = 0;
    chk("t5_ack_term_tick", tick_o, 1);
    chk("t5_ack_term_ovr", ovr_o, 0);

`ifdef TICK_BOOST_EN
    // 6: boost halves the terminal, period output unchanged
    stop_r = 1; step(); stop_r = 0; step(); step();
    auto_ack = 1; boost_r = 1;
    start_r = 1; step(); start_r = 0;
    spacing("t6_boost_gap", 5);
    chk("t6_period", period_o, 9);
    boost_r = 0;
`endif

    // 6: synchronous reset mid-run
    auto_ack = 1;
    start_r = 1; lvl_r = 1; step(); start_r = 0; lvl_r = 0;
    repeat (5) step();
    rst_r = 1; step(); rst_r = 0;
    chk_reset_vals("midrst");

    // random soak
    auto_ack = 0;
    repeat (2000) begin
      rst_r   = ($urandom_range(0, 199) == 0);
      stop_r  = ($urandom_range(0, 49) == 0);
      pause_r = ($urandom_range(0, 19) == 0);
      start_r = ($urandom_range(0, 7) == 0);
      lvl_r   = ($urandom_range(0, 15) == 0);
      ack_r   = ($urandom_range(0, 2) == 0);
      boost_r = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
